// File: rtl/baud_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : baud_pkg
//  Description : Shared types and constants for the fractional baud tick
//                generator (FSM state encoding, divisor floor, OVS helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package baud_pkg;

   // Run-state of the tick generator
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Smallest integer divisor accepted; smaller loads are clamped to this
   localparam int unsigned DIV_MIN = 2;

   // Oversample index at which the mid-bit sample tick is issued
   function automatic int unsigned half_of(input int unsigned ovs);
      return ovs / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/frac_period_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : frac_period_cnt
//  Description : Oversample period counter with fractional phase accumulator.
//                Each period lasts div_int clocks, or div_int+1 when the
//                previous period end produced an accumulator carry.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                clear          - hold counter/accumulator at zero, no ticks
//                restart        - phase restart; this cycle counts as clock 0
//                div_int/frac   - active divisor (div_int >= 2)
//                period_end     - combinational: current cycle ends a period
//                ovs_tick       - registered one-cycle pulse per period
//  Revision    : 1.0 - initial release
// ============================================================================
module frac_period_cnt
   import baud_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              restart,
   input  logic [CNT_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              period_end,
   output logic              ovs_tick
);

   logic [CNT_W-1:0]  r_cnt;
   logic [FRAC_W-1:0] r_acc;
   logic              r_extra;
   logic              r_ovs_tick;
   logic [CNT_W-1:0]  w_last;
   logic [FRAC_W:0]   w_sum;

   always_comb begin
      // Last count of the period; div_int >= 2 keeps this within CNT_W even
      // when div_int is all-ones and the period is stretched by one.
      w_last     = div_int - CNT_W'(1) + {{(CNT_W-1){1'b0}}, r_extra};
      w_sum      = {1'b0, r_acc} + {1'b0, div_frac};
      period_end = !clear && !restart && (r_cnt >= w_last);
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_cnt      <= '0;
         r_acc      <= '0;
         r_extra    <= 1'b0;
         r_ovs_tick <= 1'b0;
      end else if (restart) begin
         // The restart cycle itself is clock 0 of the new period, giving the
         // same latency as a cold start out of IDLE.
         r_cnt      <= CNT_W'(1);
         r_acc      <= '0;
         r_extra    <= 1'b0;
         r_ovs_tick <= 1'b0;
      end else if (period_end) begin
         r_cnt      <= '0;
         r_acc      <= w_sum[FRAC_W-1:0];
         r_extra    <= w_sum[FRAC_W];
         r_ovs_tick <= 1'b1;
      end else begin
         r_cnt      <= r_cnt + CNT_W'(1);
         r_ovs_tick <= 1'b0;
      end
   end

   assign ovs_tick = r_ovs_tick;

endmodule
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Fractional baud-rate tick generator. Produces oversample,
//                bit and mid-bit ticks; divisor is double-buffered and only
//                changes at bit boundaries (or at once while idle).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                en                  - run enable (low => IDLE, counters clear)
//                div_int, div_frac   - divisor inputs
//                div_load            - strobe capturing divisor into shadow
//                sync                - phase restart (RX start edge), RUN only
//                ovs_tick, bit_tick, mid_tick - registered 1-cycle pulses
//                cfg_err             - sticky: a loaded div_int was < 2
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen
   import baud_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int FRAC_W = 4,
   parameter int OVS    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CNT_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   input  logic              sync,
   output logic              ovs_tick,
   output logic              bit_tick,
   output logic              mid_tick,
   output logic              cfg_err
);

   localparam int IDX_W = $clog2(OVS);
   localparam int MID   = half_of(OVS);
   localparam logic [IDX_W-1:0] c_idx_last    = IDX_W'(OVS - 1);
   localparam logic [IDX_W-1:0] c_idx_pre_mid = IDX_W'(MID - 1);
   localparam logic [CNT_W-1:0] c_div_min     = CNT_W'(DIV_MIN);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_shadow_int;
   logic [FRAC_W-1:0] r_shadow_frac;
   logic [CNT_W-1:0]  r_active_int;
   logic [FRAC_W-1:0] r_active_frac;
   logic [IDX_W-1:0]  r_idx;
   logic              r_bit_tick;
   logic              r_mid_tick;
   logic              r_cfg_err;

   logic              w_load_low;
   logic [CNT_W-1:0]  w_load_int;
   logic              w_clear;
   logic              w_restart;
   logic              w_period_end;
   logic              w_bit_evt;
   logic              w_mid_evt;

   always_comb begin
      w_load_low = div_int < c_div_min;
      w_load_int = w_load_low ? c_div_min : div_int;
      w_clear    = !en;
      // en low wins over sync; sync is ignored outside RUN
      w_restart  = en && sync && (r_state == RUN);
      w_bit_evt  = w_period_end && (r_idx == c_idx_last);
      w_mid_evt  = w_period_end && (r_idx == c_idx_pre_mid);
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (en)  w_state_nxt = RUN;
         RUN:     if (!en) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- Shadow / active divisor ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow_int  <= c_div_min;
         r_shadow_frac <= '0;
         r_active_int  <= c_div_min;
         r_active_frac <= '0;
      end else begin
         if (div_load) begin
            r_shadow_int  <= w_load_int;
            r_shadow_frac <= div_frac;
         end
         if (r_state == IDLE) begin
            // Nothing is counting, so a new divisor can take effect at once
            if (div_load) begin
               r_active_int  <= w_load_int;
               r_active_frac <= div_frac;
            end else begin
               r_active_int  <= r_shadow_int;
               r_active_frac <= r_shadow_frac;
            end
         end else if (w_restart || w_bit_evt) begin
            // Old shadow value: a load coinciding with this edge waits for
            // the next bit boundary.
            r_active_int  <= r_shadow_int;
            r_active_frac <= r_shadow_frac;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg_err <= 1'b0;
      end else if (div_load && w_load_low) begin
         r_cfg_err <= 1'b1;
      end
   end

   // ---------------- Oversample index and bit/mid decode ----------------
   always_ff @(posedge clk) begin
      if (rst || w_clear || w_restart) begin
         r_idx      <= '0;
         r_bit_tick <= 1'b0;
         r_mid_tick <= 1'b0;
      end else begin
         r_bit_tick <= w_bit_evt;
         r_mid_tick <= w_mid_evt;
         if (w_period_end) begin
            r_idx <= w_bit_evt ? '0 : r_idx + IDX_W'(1);
         end
      end
   end

   frac_period_cnt #(
      .CNT_W  (CNT_W),
      .FRAC_W (FRAC_W)
   ) u_period (
      .clk        (clk),
      .rst        (rst),
      .clear      (w_clear),
      .restart    (w_restart),
      .div_int    (r_active_int),
      .div_frac   (r_active_frac),
      .period_end (w_period_end),
      .ovs_tick   (ovs_tick)
   );

   assign bit_tick = r_bit_tick;
   assign mid_tick = r_mid_tick;
   assign cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_baud_tick_gen
//  Description : Directed self-checking bench for baud_tick_gen
//                (CNT_W=16, FRAC_W=4, OVS=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_baud_tick_gen;

   localparam int CNT_W  = 16;
   localparam int FRAC_W = 4;
   localparam int OVS    = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [CNT_W-1:0]  div_int;
   logic [FRAC_W-1:0] div_frac;
   logic              div_load;
   logic              sync;
   logic              ovs_tick;
   logic              bit_tick;
   logic              mid_tick;
   logic              cfg_err;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;

   baud_tick_gen #(
      .CNT_W  (CNT_W),
      .FRAC_W (FRAC_W),
      .OVS    (OVS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .div_int  (div_int),
      .div_frac (div_frac),
      .div_load (div_load),
      .sync     (sync),
      .ovs_tick (ovs_tick),
      .bit_tick (bit_tick),
      .mid_tick (mid_tick),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   // Cycle n is the interval following the n-th rising edge
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_div(input int di, input int df);
      div_int  = CNT_W'(di);
      div_frac = FRAC_W'(df);
      div_load = 1'b1;
      step();
      div_load = 1'b0;
   endtask

   // sel: 0 = ovs_tick, 1 = bit_tick, 2 = mid_tick. Returns -1 on timeout.
   task automatic wait_sig(input int sel, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((sel == 0 && ovs_tick) || (sel == 1 && bit_tick) || (sel == 2 && mid_tick)) begin
            at = cyc;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, t, b, prev, n54, n55, nt;
      rst = 1'b1; en = 1'b0; div_load = 1'b0; sync = 1'b0;
      div_int = '0; div_frac = '0;
      step(); step(); step();
      @(negedge clk);
      check_eq("rst_ovs", ovs_tick, 0);
      check_eq("rst_bit", bit_tick, 0);
      check_eq("rst_mid", mid_tick, 0);
      check_eq("rst_err", cfg_err, 0);
      step();
      rst = 1'b0;

      // ---- integer rate, divisor loaded while idle ----
      load_div(4, 0);
      en = 1'b1; k = cyc;
      wait_sig(0, 100, t);  check_eq("int_ovs1", t - k, 4);
      wait_sig(0, 100, t);  check_eq("int_ovs2", t - k, 8);
      wait_sig(2, 100, t);  check_eq("int_mid1", t - k, 32);
      wait_sig(1, 100, t);  check_eq("int_bit1", t - k, 64);
      check_eq("int_bit_ovs", ovs_tick, 1);
      wait_sig(2, 100, t);  check_eq("int_mid2", t - k, 96);
      wait_sig(1, 100, t);  check_eq("int_bit2", t - k, 128);

      // ---- disable: no ticks, cold-start latency on re-enable ----
      step(); en = 1'b0; step();
      nt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         nt += int'(ovs_tick) + int'(bit_tick) + int'(mid_tick);
      end
      check_eq("dis_ticks", nt, 0);
      step(); en = 1'b1; k = cyc;
      wait_sig(0, 100, t);  check_eq("re_ovs1", t - k, 4);
      wait_sig(1, 100, t);  check_eq("re_bit1", t - k, 64);
      b = t;

      // ---- deferred load at index 5 ----
      for (int i = 0; i < 5; i++) wait_sig(0, 100, t);
      check_eq("dl_idx5", t - b, 20);
      step();
      load_div(8, 0);
      wait_sig(0, 100, t);  check_eq("dl_ovs_old", t - b, 24);
      wait_sig(1, 100, t);  check_eq("dl_bit", t - b, 64);
      wait_sig(0, 100, t);  check_eq("dl_ovs_new1", t - b, 72);
      wait_sig(0, 100, t);  check_eq("dl_ovs_new2", t - b, 80);

      // ---- sync at index 9, suppressing a tick due the same edge ----
      step(); en = 1'b0; step();
      load_div(4, 0);
      en = 1'b1; k = cyc;
      for (int i = 0; i < 9; i++) wait_sig(0, 100, t);
      check_eq("sy_idx9", t - k, 36);
      step(); step(); step();
      sync = 1'b1; k = cyc;
      step();
      sync = 1'b0;
      wait_sig(0, 100, t);  check_eq("sy_ovs", t - k, 4);
      wait_sig(2, 100, t);  check_eq("sy_mid", t - k, 32);
      wait_sig(1, 100, t);  check_eq("sy_bit", t - k, 64);

      // ---- fractional rate 54 + 4/16 ----
      step(); en = 1'b0; step();
      load_div(54, 4);
      en = 1'b1; k = cyc;
      wait_sig(1, 1000, t); check_eq("fr_bit1", t - k, 867);
      b = t; prev = t; n54 = 0; n55 = 0;
      for (int i = 0; i < OVS; i++) begin
         wait_sig(0, 100, t);
         if (t - prev == 54) n54++;
         else if (t - prev == 55) n55++;
         prev = t;
      end
      check_eq("fr_n55", n55, 4);
      check_eq("fr_n54", n54, 12);
      check_eq("fr_bit2_hi", bit_tick, 1);
      check_eq("fr_space1", t - b, 868);
      b = t;
      wait_sig(1, 1000, t); check_eq("fr_space2", t - b, 868);

      // ---- bad config: div_int=1 clamps to 2, cfg_err sticky ----
      step(); en = 1'b0; step();
      load_div(1, 0);
      @(negedge clk);
      check_eq("bad_err", cfg_err, 1);
      step();
      en = 1'b1; k = cyc;
      wait_sig(0, 100, t);  check_eq("bad_ovs1", t - k, 2);
      wait_sig(0, 100, t);  check_eq("bad_ovs2", t - k, 4);
      step();
      load_div(4, 0);
      @(negedge clk);
      check_eq("bad_err_sticky", cfg_err, 1);

      // ---- reset at index 10 ----
      step(); en = 1'b0; step();
      load_div(4, 0);
      en = 1'b1; k = cyc;
      for (int i = 0; i < 10; i++) wait_sig(0, 100, t);
      check_eq("rs_idx10", t - k, 40);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; k = cyc;
      @(negedge clk);
      check_eq("rs_ovs", ovs_tick, 0);
      check_eq("rs_bit", bit_tick, 0);
      check_eq("rs_mid", mid_tick, 0);
      check_eq("rs_err", cfg_err, 0);
      wait_sig(0, 100, t);  check_eq("rs_ovs1", t - k, 2);
      wait_sig(0, 100, t);  check_eq("rs_ovs2", t - k, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised fractional baud-rate tick generator for the UART TX/RX paths, succeeding the fixed-integer bit-clock divider. It produces an oversample tick, a bit tick and a mid-bit sample tick from one system clock. The divisor is runtime-programmable with a fractional part, is applied glitch-free at bit boundaries, and the phase can be resynchronised on an RX start edge. It sits between the command/config register file and the UART shift engines.

## Interface
- CNT_W, 16: width of integer divisor and period counter
- FRAC_W, 4: width of fractional divisor and phase accumulator
- OVS, 16: oversample ticks per bit; even, ≥4
- clk  in  1: system clock
- rst  in  1: synchronous, active-high reset
- en  in  1: run enable; low forces IDLE and clears all counters
- div_int  in  CNT_W: integer clocks per oversample period
- div_frac  in  FRAC_W: fractional clocks per oversample period, in 1/2^FRAC_W units
- div_load  in  1: one-cycle strobe; captures div_int/div_frac into the shadow register
- sync  in  1: one-cycle phase restart (RX start-bit edge)
- ovs_tick  out  1: one-cycle pulse per oversample period
- bit_tick  out  1: one-cycle pulse per bit period
- mid_tick  out  1: one-cycle pulse at oversample index OVS/2
- cfg_err  out  1: sticky flag, set when a loaded div_int < 2; cleared only by rst

## Operation
- Reset values: all outputs 0; shadow and active divisor = 2 (int), 0 (frac); period counter, ovs index and accumulator = 0; state IDLE.
- States:
  - IDLE to RUN when en=1.
  - RUN to IDLE when en=0.
  - IDLE forces counters and accumulator to 0 and outputs low.
- Divisor handling:
  - div_load captures the inputs into the shadow register in any state.
  - div_int < 2 is clamped to 2 and sets cfg_err.
  - Shadow copies to active immediately in IDLE, otherwise at the bit_tick cycle. This gives no mid-bit period change.
- Period length:
  - Each oversample period lasts div_int clocks, or div_int+1 when the accumulator carries.
  - At each period end, acc = acc + div_frac (mod 2^FRAC_W); the carry lengthens the next period.
  - Average period is div_int + div_frac/2^FRAC_W clocks.
- Oversample index: counts 0..OVS-1 and advances on each ovs_tick.
  - bit_tick coincides with the ovs_tick that wraps the index from OVS-1 to 0.
  - mid_tick coincides with the ovs_tick that moves the index to OVS/2.
- sync (RUN only):
  - Clears the period counter, index and accumulator on the same edge.
  - Pending shadow values are applied too.
  - sync in IDLE is ignored.
- Simultaneous events:
  - sync overrides a tick falling on the same cycle; that tick is suppressed.
  - en=0 overrides sync.
  - div_load together with bit_tick: the new value goes to the shadow and becomes active at the following bit_tick.
- Arithmetic: counters wrap only via explicit compare; no overflow at CNT_W all-ones.

## Timing
- All outputs are registered; every tick is exactly one clk cycle wide.
- First ovs_tick is high in cycle div_int after the cycle en is first sampled high, with frac=0. Counting that cycle as 0: div_int=4 gives ticks at cycles 4, 8, 12, …
- First mid_tick arrives OVS/2 periods after RUN entry or sync. First bit_tick arrives OVS periods after.
- After sync, the next ovs_tick comes a full period later. Latency is the same as RUN entry.
- rst mid-operation returns everything to reset values on that edge, including active divisor and cfg_err.

## Structure
- A shared package `baud_pkg` holds:
  - state enum {IDLE, RUN}
  - DIV_MIN = 2
  - localparam helpers for OVS/2
- One natural sub-module: `frac_period_cnt`. It holds the period counter plus fractional accumulator and emits ovs_tick. The top holds the FSM, shadow/active registers, index and bit/mid decode.

## Test plan
- Integer rate: div_int=4, frac=0, OVS=16, en held.
  - ovs_tick every 4 clk.
  - mid_tick at clk 32, bit_tick at clk 64 after en, then every 64.
- Fractional rate: div_int=54, frac=4 (115200×16 at 100 MHz).
  - Each bit has 4 periods of 55 and 12 of 54.
  - bit_tick spacing is exactly 868 clk.
- Deferred load:
  - Running at div 4, pulse div_load with 8 at index 5.
  - Period stays 4 until the next bit_tick, then becomes 8.
  - In IDLE, the load applies at once.
- sync mid-bit: at index 9 with div 4.
  - No tick on the sync cycle.
  - Next ovs_tick is 4 clk later.
  - mid_tick is 32 clk after sync.
- Bad config: load div_int=1.
  - Period becomes 2 clk and cfg_err=1.
  - A later valid load leaves cfg_err set until rst.
- Reset and disable:
  - Assert rst at index 10: all outputs 0 next cycle, divisor back to 2.
  - Dropping en: no ticks; restart latency equals a cold start.
